// File: rtl/dpwm_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// dpwm_seq_ctrl_if
// Bundles the sequencing controller's run/fault/reference inputs and the
// DPWM drive outputs into one port.
//
// Signals:
//   i_ts_last    DPWM period-end strobe (one cycle)
//   i_start      level run request
//   i_fault      level fault input
//   i_fault_clr  one-cycle fault acknowledge
//   i_ton_ref    on-time reference from the compensator
//   i_dt1/i_dt2  leading / trailing dead time requests
//   o_enable     DPWM enable
//   o_ton        DPWM on-time
//   o_dt1/o_dt2  DPWM dead times
//   o_state      IDLE=0, SS=1, RUN=2, FAULT=3
//   o_ss_done    high while in RUN
//
// Modports:
//   master  host / compensator / DPWM side (drives the i_* signals)
//   slave   the sequencing controller (drives the o_* signals)
// ---------------------------------------------------------------------------
interface dpwm_seq_ctrl_if;

    localparam int unsigned TON_W = 11;
    localparam int unsigned DT_W  = 5;
    localparam int unsigned ST_W  = 2;

    logic             i_ts_last;
    logic             i_start;
    logic             i_fault;
    logic             i_fault_clr;
    logic [TON_W-1:0] i_ton_ref;
    logic [DT_W-1:0]  i_dt1;
    logic [DT_W-1:0]  i_dt2;

    logic             o_enable;
    logic [TON_W-1:0] o_ton;
    logic [DT_W-1:0]  o_dt1;
    logic [DT_W-1:0]  o_dt2;
    logic [ST_W-1:0]  o_state;
    logic             o_ss_done;

    modport master (
        output i_ts_last,
        output i_start,
        output i_fault,
        output i_fault_clr,
        output i_ton_ref,
        output i_dt1,
        output i_dt2,
        input  o_enable,
        input  o_ton,
        input  o_dt1,
        input  o_dt2,
        input  o_state,
        input  o_ss_done
    );

    modport slave (
        input  i_ts_last,
        input  i_start,
        input  i_fault,
        input  i_fault_clr,
        input  i_ton_ref,
        input  i_dt1,
        input  i_dt2,
        output o_enable,
        output o_ton,
        output o_dt1,
        output o_dt2,
        output o_state,
        output o_ss_done
    );

endinterface

// File: rtl/dpwm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dpwm_seq_ctrl
// Sequencing controller for the 200 kHz DPWM power stage. Gates the DPWM
// enable, ramps the on-time during soft-start, tracks the compensator on-time
// reference (clamped to TON_MAX) in run, and latches a fault shutdown until
// acknowledged. On-time and dead-time updates are aligned to the DPWM
// period-end strobe so the DPWM never sees a mid-period change.
//
// Ports:
//   i_clk    system clock, shared with the DPWM
//   reset_n  synchronous active-low reset
//   bus      dpwm_seq_ctrl_if.slave: i_ts_last, i_start, i_fault,
//            i_fault_clr, i_ton_ref, i_dt1, i_dt2 in; o_enable, o_ton,
//            o_dt1, o_dt2, o_state, o_ss_done out (all registered)
//
// Parameters:
//   TON_MAX     upper clamp on every o_ton value
//   SS_STEP     on-time increment per soft-start step
//   SS_PERIODS  DPWM periods per soft-start step, 1..15
//
// Build option:
//   DPWM_SEQ_CTRL_SLEW_EN  when defined, RUN slews o_ton toward the clamped
//                          reference by at most SS_STEP per period instead
//                          of loading it directly.
// ---------------------------------------------------------------------------
module dpwm_seq_ctrl #(
    parameter logic [10:0] TON_MAX    = 11'd900,
    parameter logic [10:0] SS_STEP    = 11'd4,
    parameter int unsigned SS_PERIODS = 4
) (
    input  logic           i_clk,
    input  logic           reset_n,
    dpwm_seq_ctrl_if.slave bus
);

    localparam int unsigned TON_W = 11;
    localparam int unsigned DT_W  = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SUM_W = TON_W + 1;

    // Terminal count of the soft-start period counter.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SS_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SS    = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [TON_W-1:0] ton_q, ton_d;
    logic [DT_W-1:0]  dt1_q, dt1_d;
    logic [DT_W-1:0]  dt2_q, dt2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ss_done_q, ss_done_d;

    logic [TON_W-1:0] ref_c;
    logic [SUM_W-1:0] up_sum;
    logic [TON_W-1:0] up_c;
    logic [TON_W-1:0] run_ton_c;

    // Clamped reference and saturating step-up toward it.
    // The sum carries an extra bit so ton + step can never wrap.
    always_comb begin
        ref_c  = (bus.i_ton_ref > TON_MAX) ? TON_MAX : bus.i_ton_ref;
        up_sum = {1'b0, ton_q} + {1'b0, SS_STEP};
        up_c   = (up_sum > {1'b0, ref_c}) ? ref_c : up_sum[TON_W-1:0];
    end

`ifdef DPWM_SEQ_CTRL_SLEW_EN
    logic [TON_W-1:0] dn_diff;
    logic [TON_W-1:0] dn_c;

    // RUN on-time: move toward ref_c by at most SS_STEP, floor at zero.
    always_comb begin
        dn_diff   = (ton_q > SS_STEP) ? (ton_q - SS_STEP) : '0;
        dn_c      = (dn_diff < ref_c) ? ref_c : dn_diff;
        run_ton_c = (ref_c > ton_q) ? up_c : dn_c;
    end
`else
    // RUN on-time: load the clamped reference directly.
    always_comb begin
        run_ton_c = ref_c;
    end
`endif

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            ton_q     <= '0;
            dt1_q     <= '0;
            dt2_q     <= '0;
            cnt_q     <= '0;
            ss_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ton_q     <= ton_d;
            dt1_q     <= dt1_d;
            dt2_q     <= dt2_d;
            cnt_q     <= cnt_d;
            ss_done_q <= ss_done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        ton_d     = ton_q;
        dt1_d     = dt1_q;
        dt2_d     = dt2_q;
        cnt_d     = cnt_q;
        ss_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                en_d  = 1'b0;
                ton_d = '0;
                // A fault present in IDLE only blocks the start.
                if (bus.i_ts_last && bus.i_start && !bus.i_fault) begin
                    dt1_d   = bus.i_dt1;
                    dt2_d   = bus.i_dt2;
                    ton_d   = '0;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SS;
                end
            end

            ST_SS, ST_RUN: begin
                // Fault is immediate and outranks stop and ramp steps.
                if (bus.i_fault) begin
                    en_d    = 1'b0;
                    ton_d   = '0;
                    dt1_d   = '0;
                    dt2_d   = '0;
                    state_d = ST_FAULT;
                end else if (bus.i_ts_last) begin
                    if (!bus.i_start) begin
                        en_d    = 1'b0;
                        ton_d   = '0;
                        state_d = ST_IDLE;
                    end else if (state_q == ST_SS) begin
                        // Dead times stay frozen while ramping.
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            ton_d = up_c;
                            // up_c is bounded by ref_c, so this also covers
                            // a reference that dropped below the ramp.
                            if (up_c == ref_c) begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        ton_d = run_ton_c;
                        dt1_d = bus.i_dt1;
                        dt2_d = bus.i_dt2;
                    end
                end
            end

            ST_FAULT: begin
                en_d  = 1'b0;
                ton_d = '0;
                dt1_d = '0;
                dt2_d = '0;
                // An acknowledge while the fault is still present is dropped.
                if (bus.i_fault_clr && !bus.i_fault) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                en_d    = 1'b0;
                ton_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ss_done_d = (state_d == ST_RUN);
    end

    assign bus.o_enable  = en_q;
    assign bus.o_ton     = ton_q;
    assign bus.o_dt1     = dt1_q;
    assign bus.o_dt2     = dt2_q;
    assign bus.o_state   = state_q;
    assign bus.o_ss_done = ss_done_q;

endmodule

// File: tb/tb_dpwm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dpwm_seq_ctrl
// Directed walk through soft-start, clamp, mid-period reference change, stop,
// fault and reset, then a randomized phase. Every cycle the outputs are
// compared against a behavioural model of the sequencing rules kept in
// plain integers.
// ---------------------------------------------------------------------------
module tb_dpwm_seq_ctrl;

    localparam int TON_MAX    = 900;
    localparam int SS_STEP    = 4;
    localparam int SS_PERIODS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dpwm_seq_ctrl_if bus ();

    dpwm_seq_ctrl #(
        .TON_MAX   (11'(TON_MAX)),
        .SS_STEP   (11'(SS_STEP)),
        .SS_PERIODS(SS_PERIODS)
    ) dut (
        .i_clk  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: 0=IDLE 1=SS 2=RUN 3=FAULT
    int m_state = 0;
    int m_en    = 0;
    int m_ton   = 0;
    int m_dt1   = 0;
    int m_dt2   = 0;
    int m_per   = 0;   // periods elapsed since the last ramp step

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Applies the sequencing rules to the inputs present at the coming edge.
    task automatic model_edge();
        int refc;
        refc = (int'(bus.i_ton_ref) > TON_MAX) ? TON_MAX : int'(bus.i_ton_ref);
        if (!rst_n) begin
            m_state = 0; m_en = 0; m_ton = 0; m_dt1 = 0; m_dt2 = 0; m_per = 0;
        end else if (m_state == 0) begin
            if (bus.i_ts_last && bus.i_start && !bus.i_fault) begin
                m_dt1 = int'(bus.i_dt1); m_dt2 = int'(bus.i_dt2);
                m_ton = 0; m_en = 1; m_per = 0; m_state = 1;
            end
        end else if (m_state == 3) begin
            if (bus.i_fault_clr && !bus.i_fault) m_state = 0;
        end else if (bus.i_fault) begin
            m_en = 0; m_ton = 0; m_dt1 = 0; m_dt2 = 0; m_state = 3;
        end else if (bus.i_ts_last) begin
            if (!bus.i_start) begin
                m_en = 0; m_ton = 0; m_state = 0;
            end else if (m_state == 1) begin
                m_per++;
                if (m_per == SS_PERIODS) begin
                    m_per = 0;
                    m_ton = (m_ton + SS_STEP < refc) ? m_ton + SS_STEP : refc;
                    if (m_ton == refc) m_state = 2;
                end
            end else begin
`ifdef DPWM_SEQ_CTRL_SLEW_EN
                if (refc > m_ton) m_ton = (m_ton + SS_STEP < refc) ? m_ton + SS_STEP : refc;
                else              m_ton = (m_ton - SS_STEP > refc) ? m_ton - SS_STEP : refc;
`else
                m_ton = refc;
`endif
                m_dt1 = int'(bus.i_dt1); m_dt2 = int'(bus.i_dt2);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("cyc_state",   32'(bus.o_state),   32'(m_state));
        chk("cyc_enable",  32'(bus.o_enable),  32'(m_en));
        chk("cyc_ton",     32'(bus.o_ton),     32'(m_ton));
        chk("cyc_dt1",     32'(bus.o_dt1),     32'(m_dt1));
        chk("cyc_dt2",     32'(bus.o_dt2),     32'(m_dt2));
        chk("cyc_ss_done", 32'(bus.o_ss_done), 32'(m_state == 2));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ts_edge();
        bus.i_ts_last = 1'b1;
        tick();
        bus.i_ts_last = 1'b0;
    endtask

    task automatic period(input int len);
        idle_cycles(len - 1);
        ts_edge();
    endtask

    initial begin
        bus.i_ts_last   = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_fault     = 1'b0;
        bus.i_fault_clr = 1'b0;
        bus.i_ton_ref   = 11'd0;
        bus.i_dt1       = 5'd0;
        bus.i_dt2       = 5'd0;

        // Reset
        rst_n = 1'b0;
        idle_cycles(2);
        chk("rst_state",  32'(bus.o_state),  32'd0);
        chk("rst_enable", 32'(bus.o_enable), 32'd0);
        chk("rst_ton",    32'(bus.o_ton),    32'd0);
        chk("rst_dt1",    32'(bus.o_dt1),    32'd0);
        chk("rst_dt2",    32'(bus.o_dt2),    32'd0);
        chk("rst_ssdone", 32'(bus.o_ss_done), 32'd0);
        rst_n = 1'b1;

        // Soft-start ramp to 20 with 1000-cycle periods
        bus.i_start = 1'b1; bus.i_ton_ref = 11'd20; bus.i_dt1 = 5'd3; bus.i_dt2 = 5'd5;
        period(1000);
        chk("start_enable", 32'(bus.o_enable), 32'd1);
        chk("start_state",  32'(bus.o_state),  32'd1);
        chk("start_ton",    32'(bus.o_ton),    32'd0);
        chk("start_dt1",    32'(bus.o_dt1),    32'd3);
        for (int k = 1; k <= 5; k++) begin
            for (int p = 0; p < SS_PERIODS; p++) period(1000);
            chk("ramp_ton",   32'(bus.o_ton),   32'(4 * k));
            chk("ramp_state", 32'(bus.o_state), (k == 5) ? 32'd2 : 32'd1);
        end
        chk("ramp_ssdone", 32'(bus.o_ss_done), 32'd1);

        // Clamp
        bus.i_ton_ref = 11'd1500;
        period(20);
        chk("clamp_ton1", 32'(bus.o_ton), 32'd900);
        period(20);
        chk("clamp_ton2", 32'(bus.o_ton), 32'd900);

        // Mid-period reference and dead-time change
        bus.i_ton_ref = 11'd300;
        period(20);
        chk("mid_ton_a", 32'(bus.o_ton), 32'd300);
        idle_cycles(499);
        bus.i_ton_ref = 11'd400; bus.i_dt1 = 5'd7; bus.i_dt2 = 5'd9;
        idle_cycles(499);
        chk("mid_ton_hold", 32'(bus.o_ton), 32'd300);
        chk("mid_dt1_hold", 32'(bus.o_dt1), 32'd3);
        ts_edge();
        chk("mid_ton_new", 32'(bus.o_ton), 32'd400);
        chk("mid_dt1_new", 32'(bus.o_dt1), 32'd7);
        chk("mid_dt2_new", 32'(bus.o_dt2), 32'd9);

        // Stop mid-period takes effect at the period end
        idle_cycles(199);
        bus.i_start = 1'b0;
        idle_cycles(50);
        chk("stop_en_hold", 32'(bus.o_enable), 32'd1);
        chk("stop_st_hold", 32'(bus.o_state),  32'd2);
        ts_edge();
        chk("stop_state", 32'(bus.o_state),  32'd0);
        chk("stop_en",    32'(bus.o_enable), 32'd0);
        chk("stop_ton",   32'(bus.o_ton),    32'd0);

        // Fault in IDLE blocks the start
        bus.i_start = 1'b1; bus.i_fault = 1'b1;
        ts_edge();
        chk("idle_fault_state", 32'(bus.o_state), 32'd0);
        bus.i_fault = 1'b0;

        // Fault in SS at o_ton=8, mid-period
        bus.i_ton_ref = 11'd20;
        period(20);
        for (int p = 0; p < 2 * SS_PERIODS; p++) period(20);
        chk("ss_ton8", 32'(bus.o_ton), 32'd8);
        idle_cycles(7);
        bus.i_fault = 1'b1;
        tick();
        chk("flt_state", 32'(bus.o_state),  32'd3);
        chk("flt_en",    32'(bus.o_enable), 32'd0);
        chk("flt_ton",   32'(bus.o_ton),    32'd0);
        bus.i_fault_clr = 1'b1;
        tick();
        bus.i_fault_clr = 1'b0;
        chk("flt_clr_ignored", 32'(bus.o_state), 32'd3);
        bus.i_fault = 1'b0;
        tick();
        chk("flt_not_remembered", 32'(bus.o_state), 32'd3);
        bus.i_fault_clr = 1'b1;
        tick();
        bus.i_fault_clr = 1'b0;
        chk("flt_cleared", 32'(bus.o_state), 32'd0);

        // Reset while in RUN
        bus.i_ton_ref = 11'd12;
        period(20);
        for (int p = 0; p < 3 * SS_PERIODS; p++) period(20);
        chk("run12_state", 32'(bus.o_state), 32'd2);
        chk("run12_ton",   32'(bus.o_ton),   32'd12);
        idle_cycles(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rrst_state", 32'(bus.o_state),  32'd0);
        chk("rrst_en",    32'(bus.o_enable), 32'd0);
        chk("rrst_ton",   32'(bus.o_ton),    32'd0);
        chk("rrst_dt1",   32'(bus.o_dt1),    32'd0);

        // Step down from 100 to 90 (back-to-back strobes)
        bus.i_ton_ref = 11'd100;
        period(20);
        for (int p = 0; p < 25 * SS_PERIODS; p++) period(20);
        chk("run100_state", 32'(bus.o_state), 32'd2);
        chk("run100_ton",   32'(bus.o_ton),   32'd100);
        bus.i_ton_ref = 11'd90;
        ts_edge();
`ifdef DPWM_SEQ_CTRL_SLEW_EN
        chk("slew_ton1", 32'(bus.o_ton), 32'd96);
        ts_edge();
        chk("slew_ton2", 32'(bus.o_ton), 32'd92);
        ts_edge();
        chk("slew_ton3", 32'(bus.o_ton), 32'd90);
`else
        chk("direct_ton", 32'(bus.o_ton), 32'd90);
        ts_edge();
        chk("direct_ton_hold", 32'(bus.o_ton), 32'd90);
`endif

        // Randomized phase
        for (int i = 0; i < 6000; i++) begin
            bus.i_ts_last = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 2) bus.i_start = ~bus.i_start;
            if (bus.i_fault) bus.i_fault = ($urandom_range(0, 7) != 0);
            else             bus.i_fault = ($urandom_range(0, 299) == 0);
            bus.i_fault_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0) bus.i_ton_ref = 11'($urandom_range(0, 2047));
                else                           bus.i_ton_ref = 11'($urandom_range(0, 60));
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.i_dt1 = 5'($urandom_range(0, 31));
                bus.i_dt2 = 5'($urandom_range(0, 31));
            end
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end
        bus.i_ts_last = 1'b0;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dpwm_seq_ctrl.md
Name: dpwm_seq_ctrl

Overview:
- Sequencing controller for the 200 kHz DPWM power stage: gates the DPWM enable and supplies its on-time and dead-time inputs.
- Implements soft-start ramp, run-time tracking of the compensator on-time reference with clamp, and latched fault shutdown.
- Sits between the digital compensator or host registers and the DPWM, paced by the DPWM period-end strobe.

Parameters:
- TON_MAX, 11'd900, upper clamp applied to every o_ton value.
- SS_STEP, 11'd4, on-time increment per soft-start step.
- SS_PERIODS, 4, DPWM periods per soft-start step; legal range 1..15.

Ports:
- i_clk  in  1  system clock, same clock as the DPWM.
- reset_n  in  1  synchronous, active-low reset.
- i_ts_last  in  1  one-cycle strobe, high on the last count of each DPWM period.
- i_start  in  1  level run request.
- i_fault  in  1  level fault input, e.g. over-current comparator.
- i_fault_clr  in  1  one-cycle fault acknowledge.
- i_ton_ref  in  11  on-time reference from the compensator.
- i_dt1  in  5  leading dead time.
- i_dt2  in  5  trailing dead time.
- o_enable  out  1  drives the DPWM enable.
- o_ton  out  11  drives the DPWM on-time.
- o_dt1  out  5  drives the DPWM leading dead time.
- o_dt2  out  5  drives the DPWM trailing dead time.
- o_state  out  2  state code: IDLE=0, SS=1, RUN=2, FAULT=3.
- o_ss_done  out  1  high while in RUN.

Behaviour:
- Reset: applies on an i_clk edge with reset_n=0.
  - State goes to IDLE.
  - o_enable, o_ton, o_dt1, o_dt2, o_ss_done all go to 0.
  - Period counter and soft-start target are cleared.
- Parameter updates: o_ton, o_dt1 and o_dt2 change only on an edge where i_ts_last=1, except in FAULT and on reset.
  - The DPWM latches its on-time at that same edge, so a new o_ton takes effect one DPWM period later. This one-period latency is required.
- ref_c = min(i_ton_ref, TON_MAX), compared as 11-bit unsigned values.
- IDLE:
  - o_enable=0, o_ton=0.
  - If i_start=1 and i_fault=0 at an i_ts_last edge: o_dt1/o_dt2 <= i_dt1/i_dt2, o_ton <= 0, o_enable <= 1, period counter <= 0, go to SS.
- SS:
  - Each i_ts_last increments the period counter.
  - When the counter reaches SS_PERIODS-1: counter <= 0 and o_ton <= min(o_ton + SS_STEP, ref_c). The sum is computed 12 bits wide, so it saturates and never wraps.
  - When the updated o_ton equals ref_c, go to RUN on that same edge.
  - If ref_c falls below the current o_ton during SS, o_ton <= ref_c at the next step and go to RUN.
  - Dead times stay frozen during SS.
- RUN:
  - At each i_ts_last: o_ton <= ref_c, o_dt1 <= i_dt1, o_dt2 <= i_dt2.
  - o_ss_done=1.
- Stop: i_start=0 in SS or RUN has effect at the next i_ts_last, never mid-period.
  - o_enable <= 0, o_ton <= 0, go to IDLE.
- FAULT entry: i_fault=1 in any state except IDLE is sampled every cycle.
  - On the next edge: o_enable <= 0, o_ton <= 0, go to FAULT. This is immediate and not aligned to i_ts_last.
  - Fault has priority over stop and over any ramp step on the same edge.
  - i_fault in IDLE only blocks the start.
- FAULT: outputs held at 0.
  - Leave to IDLE only on an edge with i_fault_clr=1 and i_fault=0.
  - i_fault_clr while i_fault=1 is ignored. The pulse is not remembered.
- Reset mid-operation: the next edge with reset_n=0 forces the full reset state from any state, including FAULT.
- i_ts_last arriving on consecutive cycles is treated as separate periods. No filtering is applied.

Optional Feature:
- Macro: DPWM_SEQ_CTRL_SLEW_EN.
- Defined: in RUN, each i_ts_last moves o_ton toward ref_c by at most SS_STEP.
  - Increase: o_ton <= min(o_ton + SS_STEP, ref_c).
  - Decrease: o_ton <= max(o_ton - SS_STEP, ref_c), with no underflow.
  - o_ss_done stays 1 while in RUN.
- Undefined: RUN loads ref_c directly, as specified above.

Test Plan:
- Reset then start: SS_STEP=4, SS_PERIODS=4, i_ton_ref=20, i_ts_last every 1000 cycles, i_start=1.
  - Required: o_enable rises at the first i_ts_last.
  - o_ton steps 4, 8, 12, 16, 20, one step every 4 periods.
  - o_state goes 1 then 2, with RUN entered on the edge where o_ton reaches 20.
- Clamp: in RUN with i_ton_ref=1500 -> o_ton=900 at the next i_ts_last and never above 900.
- Mid-period ref change: in RUN, change i_ton_ref 300->400 at cycle 500 of a period.
  - Required: o_ton stays 300 until the i_ts_last edge, then becomes 400.
  - Dead times follow the same rule.
- Fault in SS at o_ton=8, mid-period:
  - Required: o_enable=0 and o_ton=0 on the next edge, o_state=3.
  - i_fault_clr while i_fault=1 leaves o_state=3.
  - i_fault_clr with i_fault=0 gives o_state=0.
- Stop and reset: in RUN, drop i_start at cycle 200.
  - Required: o_enable stays 1 until i_ts_last, then o_state=0.
  - Separately, reset_n=0 for one edge in RUN -> all outputs 0, o_state=0.
- DPWM_SEQ_CTRL_SLEW_EN defined, in RUN at o_ton=100, i_ton_ref=90, SS_STEP=4:
  - Required: o_ton goes 96, 92, 90 on three successive i_ts_last edges.
  - Without the macro: o_ton=90 at the first i_ts_last.
